// File: rtl/cam_frame_writer.sv
// cam_frame_writer: camera capture DMA stage feeding mem_controller.
// Packs four byte-wide pixels into a little-endian 32-bit word (pixel 0 in
// bits [7:0]). Packed words pass through a small FIFO and are written as
// single-cycle writes into the frame buffer at BASE_ADDR.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse in IDLE: arm capture of one frame
//   frame_start       camera vsync pulse
//   pix_valid/pix_data  pixel stream
//   mem_grant         memory port available this cycle
//   address/data_in/we  write port to mem_controller (registered)
//   busy              FSM not IDLE
//   frame_done        pulse: last word of the frame has been written
//   overflow          sticky: a packed word was dropped on a full FIFO
//   restart_err       sticky: frame_start arrived mid-frame
//   buf_sel           frame buffer used by the current/last frame
//
// Build option: define CAM_DOUBLE_BUFFER_EN to alternate between BASE_ADDR
// and BASE_ADDR+BUF_STRIDE on each frame; otherwise buf_sel is tied to 0.
module cam_frame_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0005_0000,
  parameter int unsigned FRAME_WORDS = 4800,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] BUF_STRIDE  = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        mem_grant,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic        we,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic        restart_err,
  output logic        buf_sel
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

  logic [1:0]    state;
  logic [1:0]    pix_cnt;
  logic [15:0]   word_idx;
  logic [23:0]   wbuf;
  logic [15:0]   fifo_idx  [FIFO_DEPTH];
  logic [31:0]   fifo_word [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic          resync, in_capt, take, push, pop, full, wr_en, last;
  logic [1:0]    cur_cnt;
  logic [15:0]   cur_idx;
  logic [31:0]   base;

  // frame_start in ARMED or CAPTURE restarts counting; a pixel in the same
  // cycle is pixel 0 of the new frame.
  always_comb begin
    resync  = frame_start && (state == S_ARMED || state == S_CAPTURE);
    in_capt = (state == S_CAPTURE) || resync;
    cur_cnt = resync ? 2'd0 : pix_cnt;
    cur_idx = resync ? '0 : word_idx;
    take    = in_capt && pix_valid;
    push    = take && (cur_cnt == 2'd3);
    last    = push && (cur_idx == LAST_IDX);
    pop     = (count != '0) && mem_grant;
    full    = (count == FULL_CNT);
    // a pop in the same cycle frees the slot for the push
    wr_en   = push && (!full || pop);
  end

  assign busy = (state != S_IDLE);
  assign base = BASE_ADDR + (buf_sel ? BUF_STRIDE : '0);

  // FIFO storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_idx[wr_ptr]  <= cur_idx;
      fifo_word[wr_ptr] <= {pix_data, wbuf};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      we      <= 1'b0;
      address <= '0;
      data_in <= '0;
    end else begin
      we <= pop;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        address <= base + {14'd0, fifo_idx[rd_ptr], 2'b00};
        data_in <= fifo_word[rd_ptr];
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pix_cnt     <= '0;
      word_idx    <= '0;
      wbuf        <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      restart_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE && start) begin
        state       <= S_ARMED;
        overflow    <= 1'b0;
        restart_err <= 1'b0;
      end
      if (state == S_CAPTURE && frame_start) restart_err <= 1'b1;
      if (in_capt) begin
        state    <= last ? S_DRAIN : S_CAPTURE;
        pix_cnt  <= cur_cnt + {1'b0, take};
        word_idx <= cur_idx + {15'd0, push};
        if (take) begin
          case (cur_cnt)
            2'd0:    wbuf[7:0]   <= pix_data;
            2'd1:    wbuf[15:8]  <= pix_data;
            2'd2:    wbuf[23:16] <= pix_data;
            default: ;
          endcase
        end
      end
      if (push && full && !pop) overflow <= 1'b1;
      if (state == S_DRAIN && count == '0) begin
        state      <= S_IDLE;
        frame_done <= 1'b1;
      end
    end
  end

`ifdef CAM_DOUBLE_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      buf_sel <= 1'b0;
    else if (state == S_DRAIN && count == '0)
      buf_sel <= ~buf_sel;
  end
`else
  assign buf_sel = 1'b0;
`endif

endmodule

// File: tb/tb_cam_frame_writer.sv
module tb_cam_frame_writer;
  localparam int unsigned FW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] BASE   = 32'h0005_0000;
  localparam logic [31:0] STRIDE = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, frame_start = 1'b0, pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        mem_grant = 1'b1;
  logic [31:0] address, data_in;
  logic        we, busy, frame_done, overflow, restart_err, buf_sel;

  cam_frame_writer #(
    .BASE_ADDR(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH), .BUF_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .mem_grant(mem_grant),
    .address(address), .data_in(data_in), .we(we), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .restart_err(restart_err),
    .buf_sel(buf_sel)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, last_we_cyc = -10, done_cnt = 0;
  int   grant_mode = 1;   // 0 low, 1 high, 2 toggle every cycle
  logic exp_buf = 1'b0;
  logic g_edge;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Write/done monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    g_edge = mem_grant;
    #1;
    cyc++;
    if (we) begin
      check("we_had_grant", {31'd0, g_edge}, 32'd1);
      check("we_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", address, e.a);
        check("wr_data", data_in, e.d);
      end
      last_we_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      check("done_after_last_we", cyc - last_we_cyc, 32'd1);
      check("busy_low_with_done", {31'd0, busy}, 32'd0);
      check("all_words_written", sb.size(), 32'd0);
    end
  end

  task automatic step(input logic s, input logic fs, input logic pv, input logic [7:0] pd);
    @(negedge clk);
    start = s; frame_start = fs; pix_valid = pv; pix_data = pd;
    case (grant_mode)
      0:       mem_grant = 1'b0;
      1:       mem_grant = 1'b1;
      default: mem_grant = ~mem_grant;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [31:0] exp_addr(input int w);
    return BASE + (exp_buf ? STRIDE : 32'd0) + 32'(4 * w);
  endfunction

  // Drives npix pixels starting at byte value seed; words with index < keep
  // are expected to reach memory.
  task automatic send_pixels(input logic [7:0] seed, input int npix, input int keep, input bit fs_first);
    logic [31:0] wd;
    logic [7:0]  b;
    wd = '0;
    for (int p = 0; p < npix; p++) begin
      b = seed + 8'(p);
      wd[8*(p%4) +: 8] = b;
      if (p % 4 == 3 && p / 4 < keep) sb.push_back('{exp_addr(p / 4), wd});
      step(1'b0, fs_first && p == 0, 1'b1, b);
    end
    idle(1);
  endtask

  task automatic arm();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
  endtask

  task automatic wait_done(input string tag);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < 300) begin
      idle(1);
      i++;
    end
    check(tag, done_cnt - d0, 32'd1);
`ifdef CAM_DOUBLE_BUFFER_EN
    exp_buf = ~exp_buf;
`endif
    check({tag, "_buf_sel"}, {31'd0, buf_sel}, {31'd0, exp_buf});
  endtask

  initial begin
    idle(3);
    check("reset_addr", address, 32'd0);
    check("reset_flags", {26'd0, we, busy, frame_done, overflow, restart_err, buf_sel}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame, pixel 0 arrives with frame_start.
    arm();
    check("busy_armed", {31'd0, busy}, 32'd1);
    send_pixels(8'h01, 4 * FW, FW, 1'b1);
    wait_done("t1_done");

    // Async reset mid-capture, then pixels without start must not write.
    arm();
    send_pixels(8'h61, 6, 1, 1'b1);
    idle(2);
    check("busy_capture", {31'd0, busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_addr", address, 32'd0);
    check("async_rst_data", data_in, 32'd0);
    check("async_rst_flags", {26'd0, we, busy, frame_done, overflow, restart_err, buf_sel}, 32'd0);
    check("async_rst_no_pending", sb.size(), 32'd0);
    exp_buf = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_pixels(8'h70, 4 * FW, 0, 1'b1);
    idle(4);
    check("no_start_idle", {31'd0, busy}, 32'd0);

    // FIFO overflow with grant held low.
    arm();
    grant_mode = 0;
    send_pixels(8'h20, 4 * FW, DEPTH, 1'b1);
    idle(3);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("stalled_words", sb.size(), DEPTH);
    grant_mode = 1;
    wait_done("t3_done");
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // frame_start mid-frame: resync and restart_err.
    arm();
    check("overflow_cleared", {31'd0, overflow}, 32'd0);
    send_pixels(8'h30, 6, 1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    check("restart_err_set", {31'd0, restart_err}, 32'd1);
    send_pixels(8'hA0, 4 * FW, FW, 1'b0);
    wait_done("t4_done");
    check("restart_err_sticky", {31'd0, restart_err}, 32'd1);

    // Grant toggling every cycle.
    grant_mode = 2;
    arm();
    check("restart_err_cleared", {31'd0, restart_err}, 32'd0);
    send_pixels(8'h40, 4 * FW, FW, 1'b1);
    wait_done("t5_done");
    grant_mode = 1;

    // Two back-to-back frames (buffer alternation when enabled).
    arm();
    send_pixels(8'h50, 4 * FW, FW, 1'b1);
    wait_done("t6a_done");
    arm();
    send_pixels(8'h58, 4 * FW, FW, 1'b1);
    wait_done("t6b_done");

    idle(3);
    check("final_idle", {31'd0, busy}, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cam_frame_writer.md
Name: cam_frame_writer

Overview:
- Capture DMA stage directly upstream of mem_controller.
- Takes a byte-wide camera pixel stream and packs 4 pixels into a 32-bit word.
- Buffers packed words in a small FIFO, then issues single-cycle writes on the mem_controller port (address, data_in, we) into the frame region at 0x50000.
- CPU reads the captured frame back through the same controller once frame_done fires.

Parameters:
- BASE_ADDR, 32'h0005_0000: byte address of word 0 of the frame buffer.
- FRAME_WORDS, 4800: 32-bit words per frame (19200 pixels); must be ≥1 and < 2^16.
- FIFO_DEPTH, 4: word FIFO entries; power of two, ≥2.
- BUF_STRIDE, 32'h0000_8000: byte offset of the second buffer (used only with CAM_DOUBLE_BUFFER_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: arm capture of one frame.
- frame_start  in  1  one-cycle vsync pulse from camera front end.
- pix_valid  in  1  pix_data valid this cycle.
- pix_data  in  8  pixel byte.
- mem_grant  in  1  1 = writer may use the memory port this cycle.
- address  out  32  byte address to mem_controller.
- data_in  out  32  write data to mem_controller.
- we  out  1  write enable to mem_controller.
- busy  out  1  state not IDLE.
- frame_done  out  1  one-cycle pulse: last word of frame written.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- restart_err  out  1  sticky: frame_start arrived mid-frame.
- buf_sel  out  1  buffer used by the current/last frame.

Behaviour:
- Reset (async, rst_n=0) forces:
  - address=0, data_in=0, we=0, busy=0, frame_done=0, overflow=0, restart_err=0, buf_sel=0.
  - State IDLE, FIFO empty, all counters 0.
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
  - IDLE: on start, clear overflow/restart_err and go to ARMED. start in any other state is ignored.
  - ARMED: on frame_start, go to CAPTURE with pixel and word index 0. A pix_valid in the same cycle as frame_start counts as pixel 0.
  - CAPTURE: each pix_valid writes pix_data into byte lane (pix_cnt mod 4); pixel 0 goes to bits[7:0] (little-endian). On the 4th byte, push {word_idx, word} into the FIFO and increment word_idx. When word_idx reaches FRAME_WORDS, go to DRAIN.
  - DRAIN: when the FIFO is empty and no write is pending, pulse frame_done for 1 cycle and go to IDLE.
- pix_valid outside CAPTURE is ignored. pix_valid in the cycle the last word is pushed is that last pixel; later pixels are ignored.
- Write issue: on any edge where the FIFO is non-empty and mem_grant=1, pop the head and register:
  - we=1
  - address = base + 4*idx
  - data_in = word
  - Otherwise we=0; address and data_in hold their values.
- Latency: the 4th pixel at edge N is pushed at N. The earliest we is at edge N+1 (grant sampled before N+1). Exactly one cycle of we per word.
- Push and pop in the same cycle are legal when the FIFO is full; the pop frees the slot first.
- FIFO full on push (no pop that cycle): word dropped, overflow set, word_idx still increments. Surviving words keep correct addresses; the dropped slot is left unwritten.
- frame_start during CAPTURE:
  - Set restart_err.
  - Discard the partial word; the FIFO is not flushed.
  - Reset pix_cnt and word_idx to 0 and remain in CAPTURE (resync to the new frame).
- frame_start in DRAIN or IDLE is ignored.
- mem_grant=0 indefinitely stalls writes; capture continues until the FIFO fills.
- busy=1 in ARMED/CAPTURE/DRAIN. It falls in the same cycle frame_done is asserted.

Optional Feature:
CAM_DOUBLE_BUFFER_EN
- Defined:
  - base = BASE_ADDR + (buf_sel ? BUF_STRIDE : 0).
  - buf_sel toggles on each frame_done, so the CPU reads buffer !buf_sel while the next frame captures.
- Undefined:
  - base = BASE_ADDR always.
  - buf_sel is tied to 0.

Test Plan:
1. FRAME_WORDS=2, mem_grant=1; start, frame_start with pixels 01..08 on consecutive cycles:
   - we at 0x50000 with data 0x04030201, then at 0x50004 with 0x08070605.
   - frame_done one cycle after the last write; busy falls with it.
2. Async reset asserted mid-CAPTURE between clock edges → all outputs 0 immediately; after release, start is required before any write.
3. FIFO_DEPTH=2, FRAME_WORDS=4, mem_grant=0 for 16 pixels, then 1:
   - Writes only to 0x50000 and 0x50004; overflow=1.
   - frame_done after the 2nd write.
4. frame_start after 6 pixels (1 word pushed), then 8 more pixels A0..A7 (FRAME_WORDS=2):
   - restart_err=1.
   - Writes: 0x50000 old word, then 0x50000=0xA3A2A1A0, 0x50004=0xA7A6A5A4.
5. mem_grant toggling 1/0 each cycle with continuous pixels → each word written exactly once; addresses strictly +4; no we while mem_grant was low.
6. With CAM_DOUBLE_BUFFER_EN, two frames of FRAME_WORDS=1:
   - First write at 0x50000, second at 0x58000.
   - buf_sel 0→1→0.
